// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - clog2 helper used to size the iteration counter
// No ports.
// -----------------------------------------------------------------------------
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
// Control FSM for the sequential multiplier: sequences one multiplication
// through IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE and drives the datapath
// enables.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   start   in   request, only honoured in IDLE
//   busy    out  high in RUN and DONE
//   done    out  registered one-cycle pulse, coincides with prod becoming valid
//   load    out  capture operands / clear accumulator (accepted start)
//   step    out  perform one add-and-shift iteration
//   last    out  current step is the final (WIDTH-th) iteration
//   capture out  copy accumulator into the product register
// -----------------------------------------------------------------------------
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic last,
  output logic capture
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = (state == ST_RUN) || (state == ST_DONE);
    load    = (state == ST_IDLE) && start;
    step    = (state == ST_RUN);
    // Counter runs 0..WIDTH-1 across the RUN cycles, so RUN lasts WIDTH cycles.
    last    = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
    capture = (state == ST_DONE);
  end

  // Iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // done is registered so it rises together with the freshly loaded prod.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= capture;
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
// Parametrised sequential shift-and-add multiplier with start/busy/done
// handshake. One multiplication in flight; result after a fixed latency
// (done high in the cycle after edge T+WIDTH+1 for a start accepted at T).
//
// Optional feature macro: SEQ_SHIFT_ADD_MULT_SIGNED_EN
//   When defined, adds input signed_mode; with signed_mode=1 the operands are
//   two's complement and prod is the signed 2*WIDTH-bit product.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   start        in   request, sampled only when idle
//   signed_mode  in   (macro only) signed operation, captured on accept
//   mcand        in   multiplicand, captured on accepted start
//   mplier       in   multiplier, captured on accepted start
//   busy         out  operation in progress (RUN or DONE)
//   done         out  one-cycle pulse when prod becomes valid
//   prod         out  product, held until the next accepted start
// -----------------------------------------------------------------------------
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
  input  logic                 signed_mode,
`endif
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  logic [WIDTH-1:0]   mc_reg;
  logic [WIDTH-1:0]   mp_reg;
  logic [2*WIDTH-1:0] acc;
  logic               signed_q;
  logic               load;
  logic               step;
  logic               last;
  logic               capture;

  seq_mult_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .load    (load),
    .step    (step),
    .last    (last),
    .capture (capture)
  );

  // One iteration: add (or subtract) the multiplicand into the upper half
  // using a WIDTH+1-bit sum so the carry / true sign is kept, then shift the
  // whole accumulator right by one with that extra bit entering at the top.
  // sext selects sign extension of both addends (signed mode); otherwise the
  // extension bit is zero and this is the plain unsigned algorithm.
  function automatic logic [2*WIDTH-1:0] step_acc(
    input logic [2*WIDTH-1:0] acc_in,
    input logic [WIDTH-1:0]   mc,
    input logic               add,
    input logic               sub,
    input logic               sext
  );
    logic signed [WIDTH:0] hi;
    logic signed [WIDTH:0] mcx;
    logic signed [WIDTH:0] sum;
    hi  = {sext & acc_in[2*WIDTH-1], acc_in[2*WIDTH-1:WIDTH]};
    mcx = {sext & mc[WIDTH-1], mc};
    if (!add) begin
      sum = hi;
    end else if (sub) begin
      sum = hi - mcx;
    end else begin
      sum = hi + mcx;
    end
    return {sum, acc_in[WIDTH-1:1]};
  endfunction

`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signed_q <= 1'b0;
    end else if (load) begin
      signed_q <= signed_mode;
    end
  end
`else
  assign signed_q = 1'b0;
`endif

  // Datapath registers. In signed mode the multiplier MSB has negative
  // weight, so the final iteration subtracts instead of adding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mc_reg <= '0;
      mp_reg <= '0;
      acc    <= '0;
      prod   <= '0;
    end else begin
      if (load) begin
        mc_reg <= mcand;
        mp_reg <= mplier;
        acc    <= '0;
      end else if (step) begin
        acc    <= step_acc(acc, mc_reg, mp_reg[0], signed_q & last, signed_q);
        mp_reg <= mp_reg >> 1;
      end
      if (capture) begin
        prod <= acc;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mult
// Scoreboard bench: drivers push expected results (value and done cycle),
// monitors pop and compare whenever done is seen. A WIDTH=8 instance covers
// directed/random cases, reset abort and (with the macro) signed mode; a
// WIDTH=4 instance sweeps all operand pairs back to back.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_shift_add_mult;

  localparam int W  = 8;
  localparam int W4 = 4;

  typedef struct {
    logic [2*W-1:0] p;
    int             c;
  } exp8_t;

  typedef struct {
    logic [2*W4-1:0] p;
  } exp4_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            smode;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  prod;

  logic            reset4;
  logic            start4;
  logic [W4-1:0]   mcand4;
  logic [W4-1:0]   mplier4;
  logic            busy4;
  logic            done4;
  logic [2*W4-1:0] prod4;

  int    cyc;
  int    n_chk;
  int    n_fail;
  bit    sweep_done;
  exp8_t sb[$];
  exp4_t sb4[$];

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
    .signed_mode (smode),
`endif
    .mcand       (mcand),
    .mplier      (mplier),
    .busy        (busy),
    .done        (done),
    .prod        (prod)
  );

  seq_shift_add_mult #(.WIDTH(W4)) dut4 (
    .clk         (clk),
    .reset       (reset4),
    .start       (start4),
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
    .signed_mode (1'b0),
`endif
    .mcand       (mcand4),
    .mplier      (mplier4),
    .busy        (busy4),
    .done        (done4),
    .prod        (prod4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer product, signed or unsigned.
  function automatic logic [2*W-1:0] model8(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint x;
    if (sm) x = longint'($signed(a)) * longint'($signed(b));
    else    x = longint'(a) * longint'(b);
    return x[2*W-1:0];
  endfunction

  // ---------------- WIDTH=8 monitor ----------------
  int bcnt = 0;
  always @(negedge clk) begin
    exp8_t e;
    if (!reset) begin
      bcnt = 0;
    end else begin
      if (busy) begin
        bcnt = bcnt + 1;
      end else if (bcnt != 0) begin
        check("busy_len", bcnt, W + 1);
        bcnt = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("prod", prod, e.p);
          check("latency", cyc, e.c);
        end
      end
    end
  end

  // ---------------- WIDTH=4 monitor ----------------
  int last_done4 = -1;
  always @(negedge clk) begin
    exp4_t e;
    if (reset4 && done4) begin
      if (sb4.size() == 0) begin
        check("spurious_done4", 1, 0);
      end else begin
        e = sb4.pop_front();
        check("prod4", prod4, e.p);
      end
      if (last_done4 >= 0) check("spacing4", cyc - last_done4, W4 + 2);
      last_done4 = cyc;
    end
  end

  // Issue one operation on the WIDTH=8 instance. Must be called at a point
  // where the inputs may change (after a negedge). Returns at the negedge of
  // the done cycle, with start low.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input bit hold);
    int    guard;
    exp8_t e;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_timeout", 1, 0);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    smode  = sm;
    @(posedge clk);
    #1;
    e.p = model8(a, b, sm);
    e.c = cyc + W + 1;
    sb.push_back(e);
    if (!hold) start = 1'b0;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 100) begin
      mcand  = W'($urandom);
      mplier = W'($urandom);
      smode  = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    if (busy) check("done_timeout", 1, 0);
    start = 1'b0;
  endtask

  // ---------------- WIDTH=4 driver: exhaustive, back to back ----------------
  initial begin
    exp4_t e;
    int    guard;
    sweep_done = 1'b0;
    reset4  = 1'b0;
    start4  = 1'b0;
    mcand4  = '0;
    mplier4 = '0;
    repeat (3) @(negedge clk);
    reset4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      guard = 0;
      while (busy4 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      start4  = 1'b1;
      mcand4  = W4'(i >> 4);
      mplier4 = W4'(i);
      e.p = 8'((i >> 4) * (i & 15));
      sb4.push_back(e);
      @(negedge clk);
    end
    start4 = 1'b0;
    repeat (W4 + 4) @(negedge clk);
    sweep_done = 1'b1;
  end

  // ---------------- WIDTH=8 main sequence ----------------
  initial begin
    int guard;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    start  = 1'b0;
    smode  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #12;
    check("rst_prod", prod, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Maximum operands.
    do_mult(8'hFF, 8'hFF, 1'b0, 1'b0);

    // Abort in the 4th RUN cycle: outputs clear without a clock edge.
    start  = 1'b1;
    mcand  = 8'h12;
    mplier = 8'h34;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_prod", prod, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    do_mult(8'h12, 8'h34, 1'b0, 1'b0);

    // Back to back: second start in the done cycle.
    do_mult(8'h0D, 8'h0B, 1'b0, 1'b0);
    do_mult(8'h00, 8'hA5, 1'b0, 1'b0);

    // Random operands, alternating held start (with operand churn) and pulse.
    for (int i = 0; i < 16; i++) begin
      do_mult(W'($urandom), W'($urandom), 1'b0, i[0]);
    end

`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
    do_mult(8'hFD, 8'h05, 1'b1, 1'b0);
    do_mult(8'h80, 8'h80, 1'b1, 1'b0);
    do_mult(8'hFD, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      do_mult(W'($urandom), W'($urandom), 1'b1, i[0]);
    end
`endif

    guard = 0;
    while (!sweep_done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("sweep_timeout", sweep_done, 1);
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("sb4_empty", sb4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
